// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32 data-memory path: access sizes, responder FSM states
// and the byte-enable helper used to place store data into a word.
package rv32_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam int MAX_LATENCY = 15;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << lane;
         SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load alignment: moves the addressed byte/halfword of a word down to bit 0 and
// sign- or zero-extends it. Also used by the core's writeback path.
module rv32_load_align
   import rv32_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word_i >> {lane_i, 3'b000};
      data_o  = '0;
      case (size_i)
         SZ_B:    data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
         SZ_H:    data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         SZ_W:    data_o = word_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait cycles, held response.
// Define RV32_DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of masking.
module rv32_dmem_responder
   import rv32_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem [DEPTH_WORDS];

   logic [IDX_W-1:0]  idx;
   logic [1:0]        lane;
   logic              misalign;
   logic              out_of_range;
   logic              fault;
   logic              access;
   logic              mem_we;
   logic [3:0]        be;
   logic [31:0]       wdata_lanes;
   logic [31:0]       load_val;

   assign idx          = addr_q[IDX_W+1:2];
   assign out_of_range = |(addr_q >> (IDX_W + 2));

   always_comb begin
      misalign = 1'b0;
      lane     = addr_q[1:0];
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
      misalign = ((size_q == SZ_H) && addr_q[0]) || ((size_q == SZ_W) && (addr_q[1:0] != 2'b00));
`else
      if (size_q == SZ_H) begin
         lane = {addr_q[1], 1'b0};
      end else if (size_q == SZ_W) begin
         lane = 2'b00;
      end
`endif
      fault = out_of_range || (size_q == 2'd3) || misalign;
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      be = byte_enable(size_q, lane);
      case (size_q)
         SZ_B:    wdata_lanes = {4{wdata_q[7:0]}};
         SZ_H:    wdata_lanes = {2{wdata_q[15:0]}};
         default: wdata_lanes = wdata_q;
      endcase
   end

   assign access = (state_q == WAIT) && (cnt_q == '0);
   assign mem_we = access && we_q && !fault;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
         end
      end
   end

   rv32_load_align u_align (
      .word_i     (mem[idx]),
      .lane_i     (lane),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (load_val)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = (fault || we_q) ? 32'd0 : load_val;
               err_d   = fault;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Randomized and directed bench for rv32_dmem_responder against a byte-array reference model.
// Honours RV32_DMEM_MISALIGN_TRAP_EN in the model when the design is built with it.
module tb_rv32_dmem_responder;

   localparam int AW      = 32;
   localparam int DEPTH   = 64;
   localparam int LAT     = 3;
   localparam int TIMEOUT = 40;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;

   int nVectors     = 0;
   int nMiscompares = 0;

   logic [7:0] mbytes [4*DEPTH];

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   rv32_dmem_responder #(
      .AW          (AW),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   // Reference: memory as a flat little-endian byte array, extension by plain arithmetic.
   function automatic void model(input op_t op, output logic [31:0] rd, output logic er);
      int          n;
      longint      a;
      longint      v;
      rd = '0;
      er = 1'b0;
      if (op.size == 2'd3) begin
         er = 1'b1;
         return;
      end
      n = 1 << op.size;
      a = longint'(op.addr);
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
      if (a % n != 0) er = 1'b1;
`else
      a = a - (a % n);
`endif
      if (a >= 4 * DEPTH) er = 1'b1;
      if (er) return;
      if (op.we) begin
         for (int i = 0; i < n; i++) mbytes[int'(a) + i] = op.wdata[8*i +: 8];
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v += longint'(mbytes[int'(a) + i]) << (8 * i);
         if (!op.uns && n < 4 && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
         rd = v[31:0];
      end
   endfunction

   task automatic issue(input op_t op);
      int k;
      req_we       = op.we;
      req_size     = op.size;
      req_unsigned = op.uns;
      req_addr     = op.addr;
      req_wdata    = op.wdata;
      req_valid    = 1'b1;
      for (k = 0; k < TIMEOUT; k++) begin
         if (req_ready) break;
         @(posedge clk); #1;
      end
      if (k == TIMEOUT) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, k);
      end
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
   endtask

   task automatic waitResp(output int lat, output logic [31:0] rd, output logic er);
      lat = -1;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, TIMEOUT);
      end
      rd = rsp_rdata;
      er = rsp_err;
   endtask

   task automatic releaseResp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic applyStimulus(input op_t op, output logic [31:0] rd, output logic er, output int lat);
      issue(op);
      waitResp(lat, rd, er);
      releaseResp();
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rsp_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nVectors += 4;
      if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_req_ready: got %0b, required 1", req_ready); end
      if (rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rsp_valid: got %0b, required 0", rsp_valid); end
      if (rsp_rdata !== 32'd0) begin nMiscompares++; $display("[TB] FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
      if (rsp_err !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_rsp_err: got %0b, required 0", rsp_err); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic init_memory();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      for (int w = 0; w < DEPTH; w++) begin
         op_t op = '{1'b1, 2'd2, 1'b0, 32'(4 * w), 32'd0};
         model(op, erd, eer);
         applyStimulus(op, rd, er, lat);
      end
   endtask

   task automatic test_store_load();
      op_t         ops [11];
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      ops[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF};
      ops[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0};
      ops[2]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080};
      ops[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0};
      ops[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0};
      ops[5]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0};
      ops[6]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h0};
      ops[7]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'hAAAA1234};
      ops[8]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0};
      ops[9]  = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0};
      ops[10] = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0};
      foreach (ops[i]) begin
         model(ops[i], erd, eer);
         applyStimulus(ops[i], rd, er, lat);
         nVectors += 3;
         if (lat != LAT) begin nMiscompares++; $display("[TB] FAIL dir%0d_latency: got %0d, required %0d", i, lat, LAT); end
         if (rd !== erd) begin nMiscompares++; $display("[TB] FAIL dir%0d_rdata: got %h, required %h", i, rd, erd); end
         if (er !== eer) begin nMiscompares++; $display("[TB] FAIL dir%0d_err: got %0b, required %0b", i, er, eer); end
      end
   endtask

   task automatic test_out_of_range();
      op_t         ops [6];
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      ops[0] = '{1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0};
      ops[1] = '{1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h55555555};
      ops[2] = '{1'b1, 2'd0, 1'b0, 32'h80000013, 32'h000000EE};
      ops[3] = '{1'b1, 2'd3, 1'b0, 32'h14, 32'h77777777};
      ops[4] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0};
      ops[5] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0};
      foreach (ops[i]) begin
         model(ops[i], erd, eer);
         applyStimulus(ops[i], rd, er, lat);
         nVectors += 2;
         if (rd !== erd) begin nMiscompares++; $display("[TB] FAIL oor%0d_rdata: got %h, required %h", i, rd, erd); end
         if (er !== eer) begin nMiscompares++; $display("[TB] FAIL oor%0d_err: got %0b, required %0b", i, er, eer); end
      end
   endtask

   task automatic test_backpressure();
      op_t         first  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0};
      op_t         second = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0};
      logic [31:0] rd, erd, erd2;
      logic        er, eer, eer2;
      int          lat;
      model(first, erd, eer);
      model(second, erd2, eer2);
      issue(first);
      waitResp(lat, rd, er);
      nVectors += 2;
      if (lat != LAT) begin nMiscompares++; $display("[TB] FAIL bp_latency: got %0d, required %0d", lat, LAT); end
      if (rd !== erd) begin nMiscompares++; $display("[TB] FAIL bp_rdata: got %h, required %h", rd, erd); end
      req_we       = second.we;
      req_size     = second.size;
      req_unsigned = second.uns;
      req_addr     = second.addr;
      req_wdata    = second.wdata;
      req_valid    = 1'b1;
      for (int h = 0; h < 5; h++) begin
         @(posedge clk); #1;
         nVectors += 3;
         if (rsp_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL bp_hold%0d_valid: got %0b, required 1", h, rsp_valid); end
         if (rsp_rdata !== erd) begin nMiscompares++; $display("[TB] FAIL bp_hold%0d_rdata: got %h, required %h", h, rsp_rdata, erd); end
         if (req_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL bp_hold%0d_req_ready: got %0b, required 0", h, req_ready); end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      nVectors += 2;
      if (rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL bp_drop_valid: got %0b, required 0", rsp_valid); end
      if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL bp_idle_ready: got %0b, required 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      nVectors++;
      if (req_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL bp_accept: req_ready=%0b, required 0", req_ready); end
      waitResp(lat, rd, er);
      releaseResp();
      nVectors += 2;
      if (lat != LAT) begin nMiscompares++; $display("[TB] FAIL bp2_latency: got %0d, required %0d", lat, LAT); end
      if (rd !== erd2) begin nMiscompares++; $display("[TB] FAIL bp2_rdata: got %h, required %h", rd, erd2); end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      req_we       = 1'b0;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_addr     = 32'h10;
      req_wdata    = '0;
      req_valid    = 1'b1;
      rsp_ready    = 1'b1;
      for (int c = 0; c < 6 * (LAT + 2); c++) begin
         if (req_ready) acc.push_back(c);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      nVectors++;
      if (acc.size() < 4) begin nMiscompares++; $display("[TB] FAIL b2b_count: got %0d accepts, required at least 4", acc.size()); end
      for (int i = 1; i < acc.size(); i++) begin
         nVectors++;
         if (acc[i] - acc[i-1] != LAT + 2) begin
            nMiscompares++;
            $display("[TB] FAIL b2b_gap%0d: got %0d cycles, required %0d", i, acc[i] - acc[i-1], LAT + 2);
         end
      end
      for (int k = 0; k < TIMEOUT; k++) begin
         if (req_ready) break;
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_midaccess();
      op_t         st = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D};
      op_t         ld = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0};
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      issue(st);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      nVectors += 2;
      if (rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_mid_valid: got %0b, required 0", rsp_valid); end
      if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rst_mid_ready: got %0b, required 1", req_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (LAT + 1) @(posedge clk);
      #1;
      nVectors += 2;
      if (rsp_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_after_valid: got %0b, required 0", rsp_valid); end
      if (req_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rst_after_ready: got %0b, required 1", req_ready); end
      model(ld, erd, eer);
      applyStimulus(ld, rd, er, lat);
      nVectors++;
      if (rd !== erd) begin nMiscompares++; $display("[TB] FAIL rst_dropped_write: got %h, required %h", rd, erd); end
   endtask

   task automatic test_random();
      op_t         op;
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      for (int i = 0; i < 250; i++) begin
         op.we    = 1'($urandom);
         op.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         op.uns   = 1'($urandom);
         op.wdata = $urandom;
         case ($urandom_range(0, 9))
            0:       op.addr = $urandom;
            1:       op.addr = 32'($urandom_range(4 * DEPTH, 4 * DEPTH + 15));
            default: op.addr = 32'($urandom_range(0, 4 * DEPTH - 1));
         endcase
         model(op, erd, eer);
         applyStimulus(op, rd, er, lat);
         nVectors += 3;
         if (lat != LAT) begin nMiscompares++; $display("[TB] FAIL rnd%0d_latency: got %0d, required %0d", i, lat, LAT); end
         if (rd !== erd) begin nMiscompares++; $display("[TB] FAIL rnd%0d_rdata: addr %h size %0d got %h, required %h", i, op.addr, op.size, rd, erd); end
         if (er !== eer) begin nMiscompares++; $display("[TB] FAIL rnd%0d_err: addr %h size %0d got %0b, required %0b", i, op.addr, op.size, er, eer); end
      end
   endtask

   initial begin
      test_reset();
      init_memory();
      test_store_load();
      test_out_of_range();
      test_backpressure();
      test_back_to_back();
      test_reset_midaccess();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
